// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
//  Shared definitions for the memory-mapped UART transmitter:
//  register offsets (addr_i[3:2]), STATUS/CTRL bit positions,
//  serialiser FSM state encoding and the address-window decode helper.
package uart_tx_mmio_pkg;

    // Register offsets, word index within the 16-byte window
    localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
    localparam logic [1:0] UART_STATUS_OFF = 2'd1;
    localparam logic [1:0] UART_CTRL_OFF   = 2'd2;
    localparam logic [1:0] UART_DIV_OFF    = 2'd3;

    // STATUS bit positions; the FIFO count field starts at STAT_COUNT_LSB
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_TX_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // 8N1 serialiser states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // True when addr falls in the 16-byte window starting at base
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return ((addr ^ base) & 32'hFFFF_FFF0) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//  Synchronous byte FIFO, 2**AW entries, feeding the UART serialiser.
//  A push while full is dropped unless a pop happens on the same edge,
//  in which case the push is accepted and the count is unchanged.
//  Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers only)
//   push, din[7:0]  write request and data
//   pop             read request; dout is the current head (first-word-fall-through)
//   empty, full     occupancy flags
//   count[AW:0]     number of stored bytes
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Accept/advance decisions and next pointer/count values
    always_comb begin
        pop_ok   = pop & ~empty;
        // a simultaneous pop frees the slot the push needs
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until pointers say otherwise
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//  Memory-mapped 8N1 UART transmitter responding on the data-RAM bus.
//  Software pushes bytes into TXDATA; the serialiser drains the FIFO onto txd_o.
//  Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ce_i, we_i   bus strobe and write enable
//   addr_i       byte address; window is addr_i[31:4]==BASE_ADDR[31:4]
//   sel_i        byte-lane selects; a write with sel_i==0 is ignored
//   data_i       write data
//   data_o       combinational read data (0 when not a read hit)
//   hit_o        access falls in this block's window
//   txd_o        serial output, idle high
//   irq_o        registered level interrupt: irq_en & FIFO empty & idle
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic        txd_o,
    output logic        irq_o
);

    // Bus decode
    logic [1:0]  reg_off;
    logic        reg_wr;
    logic        unused_data;

    // FIFO interface
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic [FIFO_AW:0] fifo_count;

    // Control/status registers
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] bauddiv_q, bauddiv_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;

    // Serialiser state
    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;      // divisor shadow, fixed for a whole frame
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        txd_q, txd_d;
    logic [2:0]  next_bit;
    logic        start_ok;

    assign hit_o       = ce_i & in_window(addr_i, BASE_ADDR);
    assign reg_off     = addr_i[3:2];
    assign reg_wr      = hit_o & we_i & (sel_i != 4'b0000);
    assign fifo_push   = reg_wr & (reg_off == UART_TXDATA_OFF);
    assign start_ok    = ctrl_q[CTRL_TX_EN_BIT] & ~fifo_empty;
    assign txd_o       = txd_q;
    assign irq_o       = irq_q;
    assign unused_data = ^data_i[31:16];

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Same-cycle read mux; writes and misses return zero
    always_comb begin
        data_o = 32'h0000_0000;
        if (hit_o && !we_i) begin
            case (reg_off)
                UART_STATUS_OFF: begin
                    data_o[STAT_EMPTY_BIT] = fifo_empty;
                    data_o[STAT_FULL_BIT]  = fifo_full;
                    data_o[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
                    data_o[STAT_OVF_BIT]   = ovf_q;
                    data_o[STAT_COUNT_LSB +: FIFO_AW+1] = fifo_count;
                end
                UART_CTRL_OFF:   data_o[1:0]  = ctrl_q;
                UART_DIV_OFF:    data_o[15:0] = bauddiv_q;
                default:         data_o = 32'h0000_0000;
            endcase
        end else begin
            data_o = 32'h0000_0000;
        end
    end

    // Register writes, sticky overflow flag and interrupt request
    always_comb begin
        ctrl_d    = ctrl_q;
        bauddiv_d = bauddiv_q;
        if (reg_wr) begin
            case (reg_off)
                UART_CTRL_OFF: ctrl_d    = data_i[1:0];
                UART_DIV_OFF:  bauddiv_d = data_i[15:0];
                default: begin
                    ctrl_d    = ctrl_q;
                    bauddiv_d = bauddiv_q;
                end
            endcase
        end else begin
            ctrl_d    = ctrl_q;
            bauddiv_d = bauddiv_q;
        end
        // a dropped byte is a push into a full FIFO with no pop on that edge
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (reg_wr && (reg_off == UART_STATUS_OFF) && data_i[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        irq_d = ctrl_q[CTRL_IRQ_EN_BIT] & fifo_empty & (state_q == ST_IDLE);
    end

    // Serialiser next-state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        next_bit = bit_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    div_d    = bauddiv_q;
                    txd_d    = 1'b0;
                    state_d  = ST_START;
                end else begin
                    txd_d    = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == div_q) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == div_q) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = next_bit;
                        txd_d   = shift_q[next_bit];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == div_q) begin
                    cnt_d = 16'd0;
                    // chain straight into the next frame with no idle bit
                    if (start_ok) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        div_d    = bauddiv_q;
                        txd_d    = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        txd_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serialiser registers; reset forces the line high immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= 8'h00;
            div_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // Control/status registers and interrupt flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= 2'b00;
            bauddiv_q <= DIV_RESET;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            bauddiv_q <= bauddiv_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio
//  Self-checking bench for uart_tx_mmio. Expected line waveforms come from
//  a frame model (start bit, 8 data bits LSB first, stop bit, each div+1
//  samples); register expectations are written out from the register map.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_TX   = BASE + 32'h0000_0000;
    localparam logic [31:0] A_ST   = BASE + 32'h0000_0004;
    localparam logic [31:0] A_CTRL = BASE + 32'h0000_0008;
    localparam logic [31:0] A_DIV  = BASE + 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hit_o;
    logic        txd_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .hit_o  (hit_o),
        .txd_o  (txd_o),
        .irq_o  (irq_o)
    );

    // Reference: line level for every clock of one 8N1 frame
    function automatic void model_frame(input logic [7:0] b, input int div);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c <= div; c++) begin
                if (k == 0)      exp_q.push_back(1'b0);
                else if (k == 9) exp_q.push_back(1'b1);
                else             exp_q.push_back(b[k-1]);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; sel_i = 4'h0; data_i = 32'h0;
    endtask

    task automatic bus_set_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_set_write(a, d, s);
        step();
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF; data_i = 32'h0;
        #1;
        d = data_o;
        h = hit_o;
        bus_idle();
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic h;
        rst = 1'b1;
        bus_idle();
        step();
        step();
        n_checks++;
        if (txd_o !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd_o); end
        rst = 1'b0;
        step();
        n_checks++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got hit=%b data=%h expected hit=0 data=0", hit_o, data_o);
        end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_0001 || h !== 1'b1) begin
            n_fail++; $display("FAIL reset_status: got %h hit=%b expected 00000001 hit=1", d, h);
        end
        bus_read(A_DIV, d, h);
        n_checks++;
        if (d !== 32'd433) begin n_fail++; $display("FAIL reset_div: got %0d expected 433", d); end
        bus_read(A_CTRL, d, h);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        logic h;
        logic [7:0] b;
        int div;
        bus_write(A_DIV, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'd1, 4'hF);
        exp_q.delete();
        model_frame(8'h55, 3);
        exp_q.push_back(1'b1);
        bus_write(A_TX, 32'h5555_5555, 4'b1000);
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            n_checks++;
            if (txd_o !== exp_q[i]) begin
                n_fail++; $display("FAIL frame55_txd[%0d]: got %b expected %b", i, txd_o, exp_q[i]);
            end
        end
        // random byte at a random small divisor
        for (int r = 0; r < 3; r++) begin
            b   = 8'($urandom);
            div = int'($urandom_range(0, 5));
            bus_write(A_DIV, 32'(div), 4'hF);
            exp_q.delete();
            model_frame(b, div);
            exp_q.push_back(1'b1);
            bus_write(A_TX, {4{b}}, 4'b0010);
            for (int i = 0; i < exp_q.size(); i++) begin
                step();
                n_checks++;
                if (txd_o !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_frame_txd[%0d] b=%h div=%0d: got %b expected %b", i, b, div, txd_o, exp_q[i]);
                end
            end
        end
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL frame_status_after: got %h expected 00000001", d); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        logic h;
        logic [7:0] bytes[17];
        logic [7:0] extra;
        int div;
        div = int'($urandom_range(0, 2));
        bus_write(A_CTRL, 32'd0, 4'hF);
        bus_write(A_DIV, 32'(div), 4'hF);
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            bus_write(A_TX, {24'h0, bytes[i]}, 4'b0001);
        end
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_100A) begin n_fail++; $display("FAIL ovf_status: got %h expected 0000100A", d); end
        bus_write(A_ST, 32'h0000_0008, 4'hF);
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00001002", d); end
        extra = 8'($urandom);
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_frame(bytes[i], div);
        model_frame(extra, div);
        exp_q.push_back(1'b1);
        bus_write(A_CTRL, 32'd1, 4'hF);
        for (int i = 0; i < exp_q.size(); i++) begin
            // push into a full FIFO on the same edge as the first pop
            if (i == 0) bus_set_write(A_TX, {24'h0, extra}, 4'b0001);
            step();
            bus_idle();
            n_checks++;
            if (txd_o !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_txd[%0d]: got %b expected %b", i, txd_o, exp_q[i]);
            end
            if (i == 1) begin
                bus_read(A_ST, d, h);
                n_checks++;
                if (d !== 32'h0000_1006) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 00001006", d); end
            end
        end
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_status_after: got %h expected 00000001", d); end
    endtask

    task automatic test_baud_change();
        logic [31:0] d;
        logic h;
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        bus_write(A_DIV, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'd1, 4'hF);
        exp_q.delete();
        model_frame(b0, 3);
        model_frame(b1, 7);
        exp_q.push_back(1'b1);
        bus_write(A_TX, {4{b0}}, 4'b1000);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0)       bus_set_write(A_TX, {4{b1}}, 4'b1000);
            else if (i == 10) bus_set_write(A_DIV, 32'd7, 4'b0001);
            else              bus_idle();
            step();
            bus_idle();
            n_checks++;
            if (txd_o !== exp_q[i]) begin
                n_fail++; $display("FAIL baudchg_txd[%0d]: got %b expected %b", i, txd_o, exp_q[i]);
            end
        end
        bus_read(A_DIV, d, h);
        n_checks++;
        if (d !== 32'd7) begin n_fail++; $display("FAIL baudchg_div: got %0d expected 7", d); end
    endtask

    task automatic test_irq();
        logic [7:0] b0, b1;
        int div;
        int t;
        logic exp_irq;
        div = int'($urandom_range(0, 3));
        b0  = 8'($urandom);
        b1  = 8'($urandom);
        bus_write(A_CTRL, 32'd0, 4'hF);
        bus_write(A_DIV, 32'(div), 4'hF);
        step();
        step();
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b expected 0", irq_o); end
        bus_write(A_CTRL, 32'd3, 4'hF);
        step();
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_idle_empty: got %b expected 1", irq_o); end
        exp_q.delete();
        model_frame(b0, div);
        model_frame(b1, div);
        t = 20 * (div + 1);
        bus_write(A_TX, {4{b0}}, 4'b0100);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_before_start: got %b expected 1", irq_o); end
        for (int i = 0; i < t + 3; i++) begin
            if (i == 0) bus_set_write(A_TX, {4{b1}}, 4'b0100);
            step();
            bus_idle();
            // sample i follows edge N+i+1; line returns idle at N+t+1
            exp_irq = ((i + 1) >= (t + 2));
            n_checks++;
            if (irq_o !== exp_irq) begin
                n_fail++; $display("FAIL irq_level[%0d]: got %b expected %b", i, irq_o, exp_irq);
            end
            if (i < t) begin
                n_checks++;
                if (txd_o !== exp_q[i]) begin
                    n_fail++; $display("FAIL irq_txd[%0d]: got %b expected %b", i, txd_o, exp_q[i]);
                end
            end
        end
        bus_write(A_CTRL, 32'd1, 4'hF);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_clear_delay: got %b expected 1", irq_o); end
        step();
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq_o); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic h;
        bus_write(A_DIV, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'd1, 4'hF);
        bus_write(A_TX, 32'h0000_0000, 4'b0001);
        bus_write(A_TX, 32'h0000_0000, 4'b0001);
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if (txd_o !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_txd: got %b expected 0", txd_o); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (txd_o !== 1'b1) begin n_fail++; $display("FAIL midrst_async_txd: got %b expected 1", txd_o); end
        rst = 1'b0;
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL midrst_status: got %h expected 00000001", d); end
        bus_read(A_DIV, d, h);
        n_checks++;
        if (d !== 32'd433) begin n_fail++; $display("FAIL midrst_div: got %0d expected 433", d); end
        bus_read(A_CTRL, d, h);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl: got %h expected 0", d); end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (txd_o !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_txd[%0d]: got %b expected 1", i, txd_o); end
        end
    endtask

    task automatic test_misc();
        logic [31:0] d;
        logic h;
        bus_read(A_TX, d, h);
        n_checks++;
        if (d !== 32'h0 || h !== 1'b1) begin n_fail++; $display("FAIL txdata_read: got %h hit=%b expected 0 hit=1", d, h); end
        bus_read(BASE + 32'h10, d, h);
        n_checks++;
        if (d !== 32'h0 || h !== 1'b0) begin n_fail++; $display("FAIL outside_read: got %h hit=%b expected 0 hit=0", d, h); end
        ce_i = 1'b0; addr_i = A_DIV;
        #1;
        n_checks++;
        if (hit_o !== 1'b0) begin n_fail++; $display("FAIL no_ce_hit: got %b expected 0", hit_o); end
        bus_idle();
        bus_write(BASE + 32'h18, 32'h0000_0003, 4'hF);
        bus_write(A_DIV, 32'h0000_0005, 4'h0);
        bus_read(A_CTRL, d, h);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL outside_write_ctrl: got %h expected 0", d); end
        bus_read(A_DIV, d, h);
        n_checks++;
        if (d !== 32'd433) begin n_fail++; $display("FAIL sel0_write_div: got %0d expected 433", d); end
        bus_write(A_DIV, 32'h1234_ABCD, 4'b1000);
        bus_read(A_DIV, d, h);
        n_checks++;
        if (d !== 32'h0000_ABCD) begin n_fail++; $display("FAIL partial_sel_div: got %h expected 0000ABCD", d); end
        bus_write(A_CTRL, 32'hFFFF_FFFC, 4'b0001);
        bus_read(A_CTRL, d, h);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_upper_bits: got %h expected 0", d); end
        bus_set_write(A_DIV, 32'h0000_0000, 4'hF);
        #1;
        n_checks++;
        if (data_o !== 32'h0 || hit_o !== 1'b1) begin
            n_fail++; $display("FAIL write_data_o: got %h hit=%b expected 0 hit=1", data_o, hit_o);
        end
        step();
        bus_idle();
        bus_write(A_CTRL, 32'd1, 4'hF);
        exp_q.delete();
        model_frame(8'hFF, 0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        bus_write(A_TX, 32'hFFFF_FFFF, 4'b0100);
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            n_checks++;
            if (txd_o !== exp_q[i]) begin
                n_fail++; $display("FAIL div0_txd[%0d]: got %b expected %b", i, txd_o, exp_q[i]);
            end
        end
        bus_read(A_ST, d, h);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL div0_status: got %h expected 00000001", d); end
    endtask

    // Global time limit so the bench always ends on its own
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        bus_idle();
        test_reset();
        test_single_frame();
        test_fifo_overflow();
        test_baud_change();
        test_irq();
        test_reset_mid_frame();
        test_misc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
